// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg : shared widths and PC operation encoding for the PC/stack unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pc_pkg;

  localparam int PC_ADDR_W      = 8;
  localparam int PC_STACK_DEPTH = 4;

  // Operation chosen after priority resolution; the control unit may reuse it.
  typedef enum logic [1:0] {
    PC_INC  = 2'd0,
    PC_LOAD = 2'd1,
    PC_CALL = 2'd2,
    PC_RET  = 2'd3
  } pc_op_t;

endpackage

`default_nettype wire

// File: rtl/ret_stack.sv
// ---------------------------------------------------------------------------
// ret_stack : parametrised LIFO of return addresses; overflowing pushes and
//             underflowing pops are silently dropped.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ret_stack #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             w_do_push, w_do_pop;

  assign full_o    = (cnt_q == CW'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign w_do_pop  = pop_i && !empty_o;
  assign w_do_push = push_i && !full_o && !pop_i;
  assign count_o   = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (w_do_pop)
      cnt_d = cnt_q - CW'(1);
    else if (w_do_push)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  // Entry contents need no reset: they are only visible below the count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    always_ff @(posedge clk) begin
      if (w_do_push && (cnt_q == CW'(i)))
        mem_q[i] <= din_i;
    end
  end

  always_comb begin
    dout_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cnt_q == CW'(i + 1))
        dout_o = mem_q[i];
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_stack_unit.sv
// ---------------------------------------------------------------------------
// pc_stack_unit : registered PC with stall, jump, call/return and sticky
//                 stack-error halt.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pc_stack_unit
  import pc_pkg::*;
#(
  parameter  int          ADDR_W      = PC_ADDR_W,
  parameter  int          STACK_DEPTH = PC_STACK_DEPTH,
  parameter  logic [ADDR_W-1:0] RESET_PC = '0,
  localparam int          SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc_out,
  output logic [SP_W-1:0]   sp_out,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              err_ovf,
  output logic              err_unf
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic [ADDR_W-1:0] w_pc_inc, w_stk_top;
  logic              w_active, w_push, w_pop;
  pc_op_t            w_op;

  assign w_pc_inc = pc_q + ADDR_W'(1);
  // Any sticky error halts the unit until reset.
  assign w_active = en && !(ovf_q || unf_q);

  always_comb begin
    w_op = PC_INC;
    if (ret)
      w_op = PC_RET;
    else if (call)
      w_op = PC_CALL;
    else if (load)
      w_op = PC_LOAD;
  end

  assign w_push = w_active && (w_op == PC_CALL) && !stack_full;
  assign w_pop  = w_active && (w_op == PC_RET) && !stack_empty;

  ret_stack #(
    .WIDTH (ADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .din_i   (w_pc_inc),
    .dout_o  (w_stk_top),
    .count_o (sp_out),
    .full_o  (stack_full),
    .empty_o (stack_empty)
  );

  always_comb begin
    pc_d  = pc_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (w_active) begin
      unique case (w_op)
        PC_RET:  if (stack_empty) unf_d = 1'b1; else pc_d = w_stk_top;
        PC_CALL: if (stack_full)  ovf_d = 1'b1; else pc_d = target;
        PC_LOAD: pc_d = target;
        default: pc_d = w_pc_inc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign pc_out  = pc_q;
  assign err_ovf = ovf_q;
  assign err_unf = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_stack_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_stack_unit : directed vectors with hand-computed expectations.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pc_stack_unit;

  logic       clk = 1'b0;
  logic       rst, en, load, call, ret;
  logic [7:0] target;
  logic [7:0] pc_out;
  logic [2:0] sp_out;
  logic       stack_full, stack_empty, err_ovf, err_unf;

  int n_tests = 0;
  int n_fail  = 0;

  pc_stack_unit #(
    .ADDR_W      (8),
    .STACK_DEPTH (4),
    .RESET_PC    (8'h00)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .load        (load),
    .call        (call),
    .ret         (ret),
    .target      (target),
    .pc_out      (pc_out),
    .sp_out      (sp_out),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .err_ovf     (err_ovf),
    .err_unf     (err_unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    load = 1'b0; call = 1'b0; ret = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic op(input logic l, input logic c, input logic r, input logic [7:0] t);
    load = l; call = c; ret = r; target = t;
    tick();
    idle();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; target = 8'h00;
    idle();
    tick(); tick();
    rst = 1'b0;

    check("rst_pc",    pc_out,      0);
    check("rst_sp",    sp_out,      0);
    check("rst_empty", stack_empty, 1);
    check("rst_full",  stack_full,  0);
    check("rst_ovf",   err_ovf,     0);
    check("rst_unf",   err_unf,     0);

    // Plain increment
    en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("inc_%0d", i), pc_out, i);
    end
    check("inc_sp", sp_out, 0);

    // Single call / return
    do_reset();
    tick(); tick(); tick();
    check("pre_call_pc", pc_out, 3);
    op(0, 1, 0, 8'h40);
    check("call_pc", pc_out, 8'h40);
    check("call_sp", sp_out, 1);
    tick(); tick();
    check("sub_pc", pc_out, 8'h42);
    op(0, 0, 1, 8'h00);
    check("ret_pc", pc_out, 8'h04);
    check("ret_sp", sp_out, 0);

    // Nested calls to overflow
    op(0, 1, 0, 8'h10);
    op(0, 1, 0, 8'h20);
    op(0, 1, 0, 8'h30);
    op(0, 1, 0, 8'h50);
    check("nest_pc",   pc_out,     8'h50);
    check("nest_full", stack_full, 1);
    check("nest_sp",   sp_out,     4);
    check("nest_ovf0", err_ovf,    0);
    op(0, 1, 0, 8'h60);
    check("ovf_flag", err_ovf, 1);
    check("ovf_pc",   pc_out,  8'h50);
    check("ovf_sp",   sp_out,  4);
    for (int i = 0; i < 10; i++) tick();
    check("halt_pc", pc_out, 8'h50);
    do_reset();
    check("clr_pc",  pc_out,  0);
    check("clr_ovf", err_ovf, 0);
    check("clr_sp",  sp_out,  0);

    // Underflow halts
    op(0, 0, 1, 8'h00);
    check("unf_flag", err_unf, 1);
    check("unf_pc",   pc_out,  0);
    op(1, 0, 0, 8'h22);
    check("unf_load_ignored", pc_out, 0);
    do_reset();
    check("unf_clr", err_unf, 0);

    // Wraparound and wrapped return address
    op(1, 0, 0, 8'hFE);
    check("load_fe", pc_out, 8'hFE);
    tick();
    check("wrap_ff", pc_out, 8'hFF);
    tick();
    check("wrap_00", pc_out, 8'h00);
    op(1, 0, 0, 8'hFF);
    op(0, 1, 0, 8'h80);
    check("wcall_pc", pc_out, 8'h80);
    op(0, 0, 1, 8'h00);
    check("wret_pc", pc_out, 8'h00);
    check("wret_sp", sp_out, 0);

    // Stall ignores controls
    op(1, 0, 0, 8'h07);
    en = 1'b0;
    op(0, 1, 0, 8'h55);
    check("stall_pc", pc_out, 8'h07);
    check("stall_sp", sp_out, 0);
    en = 1'b1;
    tick();
    check("stall_not_queued", pc_out, 8'h08);

    // call+ret: ret wins, no push
    op(1, 0, 0, 8'h32);
    op(0, 1, 0, 8'h70);
    check("cr_setup_sp", sp_out, 1);
    op(0, 1, 1, 8'h99);
    check("cr_pc", pc_out, 8'h33);
    check("cr_sp", sp_out, 0);

    // load+call: call wins
    op(1, 0, 0, 8'h08);
    op(1, 1, 0, 8'h60);
    check("lc_pc", pc_out, 8'h60);
    check("lc_sp", sp_out, 1);
    op(0, 0, 1, 8'h00);
    check("lc_top", pc_out, 8'h09);

    // Mid-sequence reset with stack non-empty
    op(0, 1, 0, 8'hA0);
    rst = 1'b1;
    op(0, 1, 0, 8'hB0);
    rst = 1'b0;
    check("mid_rst_pc", pc_out, 0);
    check("mid_rst_sp", sp_out, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Parametrised program-counter unit, next generation of the computer's fixed 8-bit PC.
- Adds stall, absolute jump, subroutine call/return through an internal return-address stack, and sticky stack-error detection.
- Sits between the control unit and the instruction memory address bus; pc_out drives the IM address directly.

Parameters:
- ADDR_W, 8, width of the PC and of the IM address.
- STACK_DEPTH, 4, number of return-address entries (>=1).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  advance enable; 0 = stall (all state held).
- load  in  1  absolute jump to target.
- call  in  1  push return address, jump to target.
- ret  in  1  pop return address into PC.
- target  in  ADDR_W  jump/call destination.
- pc_out  out  ADDR_W  current PC (registered).
- sp_out  out  $clog2(STACK_DEPTH+1)  stack occupancy, 0..STACK_DEPTH.
- stack_full  out  1  sp_out == STACK_DEPTH (combinational from sp).
- stack_empty  out  1  sp_out == 0.
- err_ovf  out  1  sticky: call attempted while full.
- err_unf  out  1  sticky: ret attempted while empty.

Behaviour:
- Reset (rst=1 at posedge): pc_out=RESET_PC, sp_out=0, err_ovf=0, err_unf=0, stack contents don't-care; rst overrides every other input.
- All updates occur on the rising clk edge; pc_out reflects the decision one cycle after controls are sampled. There is no combinational path from inputs to pc_out.
- Frozen state: if err_ovf|err_unf is set, PC and stack hold until rst. Treat it as a halt.
- Priority when en=1 and not frozen: ret > call > load > increment.
  - ret, sp>0: pc <= stack[sp-1]; sp <= sp-1.
  - ret, sp=0: err_unf <= 1; pc and sp unchanged.
  - call, sp<STACK_DEPTH: stack[sp] <= pc+1 (mod 2^ADDR_W); sp <= sp+1; pc <= target.
  - call, sp=STACK_DEPTH: err_ovf <= 1; pc, sp and stack unchanged.
  - load: pc <= target; stack untouched.
  - none: pc <= pc+1, wrapping from 2^ADDR_W-1 to 0 with no flag.
- en=0: every register holds, including the error flags. Controls asserted in that cycle are ignored, not queued.
- Simultaneous call and ret: ret executes and call is dropped (no push).
- Return address pushed at pc = 2^ADDR_W-1 is 0 (wrapped).
- Reset asserted mid-sequence (stack non-empty, error set) clears everything in the same edge.

Decomposition:
- Shared package (pc_pkg) holds:
  - the default ADDR_W and STACK_DEPTH constants;
  - a 2-bit enum pc_op_t {PC_INC, PC_LOAD, PC_CALL, PC_RET}, used internally after priority resolution and reusable by the control unit.
- One sub-module: ret_stack.
  - Parametrised LIFO (WIDTH, DEPTH).
  - Inputs: push, pop, din. Outputs: dout (top entry), count, full, empty.
  - Ignores push when full and pop when empty.
- pc_stack_unit holds the PC register, the priority decode and the sticky error flags.

Test Plan:
1. Reset, then 5 cycles with en=1 and no controls -> pc_out 0,1,2,3,4,5; sp_out=0; stack_empty=1; no errors.
2. At pc=3, call with target=0x40 for one cycle -> next pc=0x40, sp_out=1. Two idle cycles -> 0x42. ret -> pc=0x04, sp_out=0.
3. Nested calls with STACK_DEPTH=4: four calls (targets 0x10,0x20,0x30,0x50) -> stack_full=1. A fifth call -> err_ovf=1, pc stays 0x50, and pc holds for 10 more cycles. rst -> pc=0, err_ovf=0, sp_out=0.
4. ret at reset state -> err_unf=1, pc stays 0. Subsequent load of 0x22 is ignored (pc=0).
5. ADDR_W=8, load 0xFE, then idle -> 0xFF, 0x00 (wrap). Load 0xFF then call 0x80 -> pushed address 0x00; ret returns pc=0x00.
6. Stall and priority:
   - en=0 with call asserted at pc=0x07 -> pc, sp unchanged.
   - en=1 with call+ret both high and sp=1 holding 0x33 -> pc=0x33, sp=0, no push.
   - load+call together with target=0x60 at pc=0x08 -> call wins: sp=1, stack top 0x09.
